// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and owner encoding.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-macro signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

    // CPU + memory-macro side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: DM has priority unless IF has waited out a full DM streak.
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int MAX_DM_STREAK = 3
) (
    input  logic       if_req,
    input  logic       dm_req,
    input  logic [2:0] streak,
    output logic       grant,
    output logic       winner
);

    logic if_due;

    always_comb begin
        if_due = if_req && (streak >= 3'(MAX_DM_STREAK));
        grant  = if_req || dm_req;
        winner = (dm_req && !if_due) ? OWNER_DM : OWNER_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// one transaction in flight, fixed LAT-cycle access followed by a one-cycle ack.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int LAT           = 2,
    parameter int MAX_DM_STREAK = 3
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);

    state_t        state, state_next;
    logic [3:0]    cnt;
    logic [2:0]    streak;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          we_q;
    logic          owner_q;
    logic          grant;
    logic          winner;

    mem_arb_pick #(
        .MAX_DM_STREAK (MAX_DM_STREAK)
    ) u_pick (
        .if_req (bus.if_req),
        .dm_req (bus.dm_req),
        .streak (streak),
        .grant  (grant),
        .winner (winner)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.busy      = 1'b0;
        bus.if_ack    = 1'b0;
        bus.dm_ack    = 1'b0;
        bus.if_rdata  = '0;
        bus.dm_rdata  = '0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.owner     = owner_q;
        unique case (state)
            IDLE: begin
                if (grant) state_next = ACCESS;
            end
            ACCESS: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q && (owner_q == OWNER_DM);
                bus.busy   = 1'b1;
                if (cnt == '0) state_next = RESP;
            end
            RESP: begin
                bus.busy = 1'b1;
                if (owner_q == OWNER_DM) begin
                    bus.dm_ack   = 1'b1;
                    bus.dm_rdata = rdata_q;
                end else begin
                    bus.if_ack   = 1'b1;
                    bus.if_rdata = rdata_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            streak  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= OWNER_IF;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q <= winner;
                        cnt     <= 4'(LAT - 1);
                        if (winner == OWNER_DM) begin
                            addr_q  <= bus.dm_addr;
                            wdata_q <= bus.dm_wdata;
                            we_q    <= bus.dm_we;
                        end else begin
                            addr_q  <= bus.if_addr;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                        end
                        // Streak only grows while IF is actually being held off.
                        if (winner == OWNER_DM && bus.if_req) begin
                            if (streak != 3'(MAX_DM_STREAK)) streak <= streak + 3'd1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) rdata_q <= we_q ? '0 : bus.mem_rdata;
                    else           cnt     <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: drivers queue expected responses, a monitor checks grants and acks
// against an arbitration model; a second instance covers the single-cycle-latency build.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXS = 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    txn_t        if_q[$];
    txn_t        dm_q[$];
    logic        grant_log[$];
    int unsigned dm_ack_cyc[$];
    bit          if_in_service = 1'b0;
    bit          dm_in_service = 1'b0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAX_DM_STREAK(MAXS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1), .MAX_DM_STREAK(MAXS)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing/unexpected expected=in-order event", name);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    // Memory macro model: data is only valid on the LAT-th consecutive enabled cycle.
    initial begin
        int run;
        run = 0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) run++;
            else                     run = 0;
            bus.mem_rdata = (run == LAT) ? mem_val(bus.mem_addr) : (32'hBAD00000 | 32'(run));
        end
    end

    // Monitor: arbitration model plus response scoreboard.
    initial begin
        logic        s_if, s_dm, s_we, w, exp_owner, cur_we;
        logic [31:0] s_if_addr, s_dm_addr, s_wdata;
        bit          en_prev, ack_prev;
        int          en_cnt, we_cnt, dm_run;
        txn_t        e;
        en_prev = 1'b0; ack_prev = 1'b0; en_cnt = 0; we_cnt = 0; dm_run = 0;
        exp_owner = OWNER_IF; cur_we = 1'b0;
        forever begin
            @(posedge clk);
            s_if = bus.if_req;  s_if_addr = bus.if_addr;
            s_dm = bus.dm_req;  s_dm_addr = bus.dm_addr;
            s_we = bus.dm_we;   s_wdata   = bus.dm_wdata;
            @(negedge clk);
            if (!reset) begin
                en_prev = 1'b0; ack_prev = 1'b0; dm_run = 0;
                if_in_service = 1'b0; dm_in_service = 1'b0;
                continue;
            end
            if (bus.mem_en && !en_prev) begin
                if (!s_if && !s_dm) flag("grant_without_request");
                w = s_dm && !(s_if && dm_run >= MAXS);
                check("grant_owner", 32'(bus.owner), 32'(w));
                check("grant_addr", bus.mem_addr, w ? s_dm_addr : s_if_addr);
                if (w && s_we) check("grant_wdata", bus.mem_wdata, s_wdata);
                exp_owner = w;
                cur_we    = w && s_we;
                dm_run    = (w && s_if) ? dm_run + 1 : 0;
                grant_log.push_back(bus.owner);
                if (w) dm_in_service = 1'b1;
                else   if_in_service = 1'b1;
                en_cnt = 0;
                we_cnt = 0;
            end
            if (bus.mem_en) en_cnt++;
            if (bus.mem_we) we_cnt++;
            check("invariants", 32'({bus.if_ack & bus.dm_ack, bus.mem_we & ~bus.mem_en,
                                     ack_prev & (bus.if_ack | bus.dm_ack)}), 32'd0);
            if (bus.if_ack || bus.dm_ack) begin
                check("ack_port", 32'(bus.dm_ack), 32'(exp_owner));
                check("access_len", 32'(en_cnt), 32'(LAT));
                check("we_len", 32'(we_cnt), cur_we ? 32'(LAT) : 32'd0);
                check("resp_busy", 32'({bus.busy, bus.mem_en}), 32'b10);
                if (bus.if_ack) begin
                    if (if_q.size() == 0) flag("if_ack_unexpected");
                    else begin
                        e = if_q.pop_front();
                        check("if_rdata", bus.if_rdata, e.rdata);
                    end
                    if_in_service = 1'b0;
                end else begin
                    if (dm_q.size() == 0) flag("dm_ack_unexpected");
                    else begin
                        e = dm_q.pop_front();
                        check("dm_rdata", bus.dm_rdata, e.rdata);
                    end
                    dm_in_service = 1'b0;
                    dm_ack_cyc.push_back(cyc);
                end
            end
            en_prev  = bus.mem_en;
            ack_prev = bus.if_ack | bus.dm_ack;
        end
    end

    task automatic if_start(input logic [31:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        if_q.push_back('{1'b0, a, 32'h0, mem_val(a)});
    endtask

    task automatic dm_start(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        dm_q.push_back('{we, a, d, we ? 32'h0 : mem_val(a)});
    endtask

    // Waits for the ack; after grant, the request fields are scrambled to prove they are latched.
    task automatic wait_if_ack(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.if_ack) begin
                got = 1'b1;
                break;
            end
            if (if_in_service && $urandom_range(1) == 1) bus.if_addr = $urandom;
        end
        if (!got) flag("if_ack_timeout");
    endtask

    task automatic wait_dm_ack(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.dm_ack) begin
                got = 1'b1;
                break;
            end
            if (dm_in_service && $urandom_range(1) == 1) begin
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
                bus.dm_we    = 1'($urandom_range(1));
            end
        end
        if (!got) flag("dm_ack_timeout");
    endtask

    initial begin
        bit          got, saw;
        int unsigned c0, ack_c;
        int          busy_n;
        logic        exp_order [8];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        bus1.mem_rdata = 32'hCAFEF00D;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({bus.if_ack, bus.dm_ack, bus.mem_en, bus.mem_we, bus.busy, bus.owner}), 32'd0);
        check("reset_data", bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.dm_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single fetch
        c0 = cyc;
        if_start(32'h10);
        wait_if_ack(20, got);
        check("fetch_latency", cyc - c0, 32'(LAT + 1));
        check("fetch_data", bus.if_rdata, 32'hDEADBEEF);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Single store
        dm_start(1'b1, 32'h40, 32'h12345678);
        wait_dm_ack(20, got);
        check("store_rdata_zero", bus.dm_rdata, 32'd0);
        bus.dm_req = 1'b0;
        repeat (2) @(negedge clk);

        // Both ports held high continuously
        grant_log.delete();
        fork
            begin
                bit g;
                repeat (2) begin
                    if_start(rand_addr());
                    wait_if_ack(60, g);
                end
                bus.if_req = 1'b0;
            end
            begin
                bit g;
                repeat (6) begin
                    dm_start(1'($urandom_range(1)), rand_addr(), $urandom);
                    wait_dm_ack(60, g);
                end
                bus.dm_req = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        check("order_len", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));

        // Back-to-back loads
        dm_ack_cyc.delete();
        repeat (4) begin
            dm_start(1'b0, rand_addr(), 32'h0);
            wait_dm_ack(20, got);
        end
        bus.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_count", 32'(dm_ack_cyc.size()), 32'd4);
        for (int i = 1; i < dm_ack_cyc.size(); i++)
            check($sformatf("b2b_spacing_%0d", i), dm_ack_cyc[i] - dm_ack_cyc[i-1], 32'(LAT + 2));

        // Request dropped after grant still completes
        dm_start(1'b0, 32'h80, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("drop_grant_timeout");
        bus.dm_req = 1'b0;
        wait_dm_ack(20, got);
        check("drop_still_acks", 32'(got), 32'd1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a store
        dm_start(1'b1, 32'h44, 32'hA5A5A5A5);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("store_we_timeout");
        #2 reset = 1'b0;
        #1 check("reset_abort", 32'({bus.mem_en, bus.mem_we, bus.busy}), 32'd0);
        bus.dm_req = 1'b0;
        dm_q.delete();
        if_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.if_ack || bus.dm_ack || bus.busy) saw = 1'b1;
        end
        check("reset_no_ack_idle", 32'(saw), 32'd0);

        // Randomised traffic on both ports
        fork
            begin
                bit g;
                for (int i = 0; i < 40; i++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        bus.if_req = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                    if_start(rand_addr());
                    wait_if_ack(60, g);
                end
                bus.if_req = 1'b0;
            end
            begin
                bit g;
                for (int i = 0; i < 40; i++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        bus.dm_req = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                    dm_start(1'($urandom_range(1)), rand_addr(), $urandom);
                    wait_dm_ack(60, g);
                end
                bus.dm_req = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("dm_q_drained", 32'(dm_q.size()), 32'd0);

        // Single-cycle-latency build: single fetch
        @(negedge clk);
        c0 = cyc;
        bus1.if_req  = 1'b1;
        bus1.if_addr = 32'h20;
        got = 1'b0; ack_c = 0; busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.busy) busy_n++;
            if (bus1.mem_en) check("lat1_addr", bus1.mem_addr, 32'h20);
            if (bus1.if_ack && !got) begin
                got   = 1'b1;
                ack_c = cyc;
                check("lat1_rdata", bus1.if_rdata, 32'hCAFEF00D);
                bus1.if_req = 1'b0;
            end
        end
        if (!got) flag("lat1_ack_timeout");
        else check("lat1_latency", ack_c - c0, 32'd2);
        check("lat1_busy_cycles", 32'(busy_n), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
